// File: rtl/keypad_scanner_if.sv
// Key interface between the keypad scanner and the calculator FSM.
// readKey is held high while a debounced key is down; pressedkey holds its code.
interface keypad_scanner_if;
  logic       readKey;
  logic [3:0] pressedkey;

  modport master (output readKey, output pressedkey);
  modport slave  (input  readKey, input  pressedkey);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with per-tick debounce.
// Encodes a held key into the calculator key code and holds readKey while down.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_scanner_if.master key
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    ASSERT,
    PRESSED,
    HOLDOFF
  } state_t;

  state_t          state, state_n;
  logic [3:0]      row_q1, row_s;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [1:0]      col_idx, col_n;
  logic [1:0]      key_row, key_row_n;
  logic [1:0]      key_col, key_col_n;
  logic [CW-1:0]   deb_cnt, deb_n, deb_inc;
  logic [CW-1:0]   rel_cnt, rel_n, rel_inc;
  logic            rk_q, rk_n;
  logic [3:0]      key_q, key_n;
  logic [1:0]      low_row;
  logic            any_low;
  logic            key_hit;

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'd1;
      4'b00_01: k = 4'd2;
      4'b00_10: k = 4'd3;
      4'b00_11: k = 4'd12;
      4'b01_00: k = 4'd4;
      4'b01_01: k = 4'd5;
      4'b01_10: k = 4'd6;
      4'b01_11: k = 4'd13;
      4'b10_00: k = 4'd7;
      4'b10_01: k = 4'd8;
      4'b10_10: k = 4'd9;
      4'b10_11: k = 4'd14;
      4'b11_00: k = 4'd11;
      4'b11_01: k = 4'd0;
      4'b11_10: k = 4'd10;
      default:  k = 4'd15;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q1 <= 4'b1111;
      row_s  <= 4'b1111;
    end else begin
      row_q1 <= row_in;
      row_s  <= row_q1;
    end
  end

  assign tick = (div_cnt == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Lowest-index low row wins when several rows of a column are down.
  always_comb begin
    low_row = 2'd3;
    if      (!row_s[0]) low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
  end

  assign any_low = ~&row_s;
  assign key_hit = ~row_s[key_row];
  assign deb_inc = (deb_cnt == CW'(DEBOUNCE_CNT)) ? deb_cnt : deb_cnt + 1'b1;
  assign rel_inc = (rel_cnt == CW'(DEBOUNCE_CNT)) ? rel_cnt : rel_cnt + 1'b1;

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    key_row_n = key_row;
    key_col_n = key_col;
    deb_n     = deb_cnt;
    rel_n     = rel_cnt;
    rk_n      = rk_q;
    key_n     = key_q;
    unique case (state)
      SCAN: if (tick) begin
        if (any_low) begin
          key_row_n = low_row;
          key_col_n = col_idx;
          deb_n     = '0;
          state_n   = DEBOUNCE;
        end else begin
          col_n = col_idx + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (key_hit) begin
          deb_n = deb_inc;
          if (deb_inc == CW'(DEBOUNCE_CNT)) begin
            key_n   = key_code(key_row, key_col);
            state_n = ASSERT;
          end
        end else begin
          col_n   = col_idx + 2'd1;
          state_n = SCAN;
        end
      end
      ASSERT: begin
        rk_n    = 1'b1;
        rel_n   = '0;
        state_n = PRESSED;
      end
      PRESSED: if (tick) begin
        rel_n = key_hit ? '0 : rel_inc;
        if (!key_hit && rel_inc == CW'(DEBOUNCE_CNT)) begin
          rk_n    = 1'b0;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: if (tick) begin
        col_n   = col_idx + 2'd1;
        state_n = SCAN;
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      col_idx <= '0;
      key_row <= '0;
      key_col <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      rk_q    <= 1'b0;
      key_q   <= '0;
    end else begin
      state   <= state_n;
      col_idx <= col_n;
      key_row <= key_row_n;
      key_col <= key_col_n;
      deb_cnt <= deb_n;
      rel_cnt <= rel_n;
      rk_q    <= rk_n;
      key_q   <= key_n;
    end
  end

  assign col_out        = ~(4'b0001 << col_idx);
  assign key.readKey    = rk_q;
  assign key.pressedkey = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix and a tick-level
// reference model of the scan/debounce rules, checked every clock.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] mat [4];

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .row_in (row_in),
    .col_out(col_out),
    .key    (kif)
  );

  always #5 clk = ~clk;

  // A row reads low when a held key sits in the column being driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(mat[r] & ~col_out);
  end

  int n_chk = 0;
  int n_fail = 0;
  int rises = 0;
  bit prev_rk = 1'b0;

  // Reference model, advanced once per clock.
  // mode: 0 hunting, 1 confirming, 2 key held, 3 resting
  int m_div, m_col, m_mode, m_row, m_kcol, m_cnt, m_key;
  bit m_rk, m_pend, m_tick;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_of(input int r, input int c);
    if (c == 3) return 12 + r;
    if (r == 3) return (c == 0) ? 11 : (c == 1) ? 0 : 10;
    return r * 3 + c + 1;
  endfunction

  function automatic bit down(input int r, input int c);
    return mat[r][c];
  endfunction

  task automatic model_step();
    int lr;
    if (reset) begin
      m_div = 0; m_col = 0; m_mode = 0; m_cnt = 0;
      m_key = 0; m_rk = 0; m_pend = 0; m_tick = 0;
      return;
    end
    if (m_pend) begin
      m_rk = 1;
      m_pend = 0;
    end
    m_tick = (m_div == SD - 1);
    m_div = m_tick ? 0 : m_div + 1;
    if (!m_tick) return;
    case (m_mode)
      0: begin
        lr = -1;
        for (int r = 3; r >= 0; r--)
          if (down(r, m_col)) lr = r;
        if (lr < 0) m_col = (m_col + 1) % 4;
        else begin
          m_row = lr; m_kcol = m_col; m_cnt = 0; m_mode = 1;
        end
      end
      1: begin
        if (down(m_row, m_kcol)) begin
          m_cnt++;
          if (m_cnt == DC) begin
            m_key = code_of(m_row, m_kcol);
            m_pend = 1; m_cnt = 0; m_mode = 2;
          end
        end else begin
          m_col = (m_col + 1) % 4; m_mode = 0;
        end
      end
      2: begin
        m_cnt = down(m_row, m_kcol) ? 0 : m_cnt + 1;
        if (m_cnt == DC) begin
          m_rk = 0; m_mode = 3;
        end
      end
      default: begin
        m_col = (m_col + 1) % 4; m_mode = 0;
      end
    endcase
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    chk("readKey", int'(kif.readKey), int'(m_rk));
    chk("pressedkey", int'(kif.pressedkey), m_key);
    chk("col_out", int'(col_out), 15 - (1 << m_col));
    if (kif.readKey && !prev_rk) rises++;
    prev_rk = kif.readKey;
  endtask

  task automatic ticks(input int n);
    int k = 0;
    while (k < n) begin
      cyc();
      if (m_tick) k++;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) mat[r] = 4'b0000;
  endtask

  initial begin
    int k, nk, r, c;
    clear_keys();
    cyc();
    cyc();
    chk("rst_readKey", int'(kif.readKey), 0);
    chk("rst_key", int'(kif.pressedkey), 0);
    chk("rst_col", int'(col_out), 4'b1110);
    reset = 1'b0;
    ticks(5);

    // Clean press of r1/c2
    rises = 0;
    mat[1] = 4'b0100;
    ticks(10);
    mat[1] = 4'b0000;
    ticks(8);
    chk("key_6", int'(kif.pressedkey), 6);
    chk("pulses_6", rises, 1);

    // Single-tick bounce on r0/c0
    k = 0;
    while (m_col != 0 && k < 8) begin
      ticks(1);
      k++;
    end
    chk("bounce_align", m_col, 0);
    rises = 0;
    mat[0] = 4'b0001;
    ticks(1);
    mat[0] = 4'b0000;
    ticks(1);
    chk("bounce_col", int'(col_out), 4'b1101);
    chk("bounce_key", int'(kif.pressedkey), 6);
    ticks(6);
    chk("bounce_pulses", rises, 0);

    // Row 3 keys in turn
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 2 : (i == 1) ? 0 : 3;
      rises = 0;
      mat[3] = 4'(1 << c);
      ticks(12);
      mat[3] = 4'b0000;
      ticks(8);
      chk("r3_key", int'(kif.pressedkey), code_of(3, c));
      chk("r3_pulses", rises, 1);
    end

    // Two rows in one column, then a foreign key while held
    rises = 0;
    mat[0] = 4'b0010;
    mat[2] = 4'b0010;
    ticks(8);
    mat[1] = 4'b1000;
    ticks(6);
    chk("multi_key", int'(kif.pressedkey), 2);
    clear_keys();
    ticks(8);
    chk("multi_pulses", rises, 1);

    // Reset while a key is held
    mat[2] = 4'b0001;
    k = 0;
    while (!m_rk && k < 200) begin
      cyc();
      k++;
    end
    chk("rk_wait", int'(m_rk), 1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_rk", int'(kif.readKey), 0);
    chk("mid_rst_key", int'(kif.pressedkey), 0);
    chk("mid_rst_col", int'(col_out), 4'b1110);
    reset = 1'b0;
    rises = 0;
    ticks(12);
    chk("post_rst_key", int'(kif.pressedkey), 7);
    clear_keys();
    ticks(8);
    chk("post_rst_pulses", rises, 1);

    // Random presses of one or two keys with random hold and gap
    for (int it = 0; it < 40; it++) begin
      nk = $urandom_range(1, 2);
      for (int j = 0; j < nk; j++) begin
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        mat[r][c] = 1'b1;
      end
      ticks($urandom_range(1, 12));
      clear_keys();
      ticks($urandom_range(0, 10));
    end
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
